conv_kernel_engine: RTL and testbench

Parametrised, fully pipelined 2-D convolution engine for the image pipeline: takes one KERNEL_W×KERNEL_W pixel window per beat, multiplies by a run-time programmable signed coefficient kernel, normalises by a programmable right shift with rounding, and saturates to an unsigned pixel. It supersedes the fixed-kernel `conv` stage. It sits between the line-buffer/window generator and the output pixel sink. It adds valid/ready backpressure and double-buffered coefficients, so the kernel can be swapped between frames without corrupting windows already in flight.

---
 rtl/conv_kernel_engine.sv | 116 +++++++++++
 tb/tb_conv_kernel_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_engine.sv
// 2-D convolution engine: signed programmable KxK kernel, rounding right shift and
// unsigned saturation, three-stage pipeline with valid/ready and double-buffered coefficients.
module conv_kernel_engine #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_W = 3,
  parameter int COEF_W   = 8,
  parameter int SHIFT_W  = 4
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0]    pixel_data_i,
  input  logic                                             pixel_data_valid_i,
  output logic                                             pixel_data_ready_o,
  input  logic                                             coef_wr_i,
  input  logic [$clog2(KERNEL_W*KERNEL_W)-1:0]             coef_addr_i,
  input  logic [COEF_W-1:0]                                coef_data_i,
  input  logic                                             shift_wr_i,
  input  logic [SHIFT_W-1:0]                               shift_data_i,
  input  logic                                             coef_swap_i,
  output logic [DATA_W-1:0]                                pixel_o,
  output logic                                             pixel_sat_o,
  output logic                                             pixel_valid_o,
  input  logic                                             pixel_ready_i
);
  localparam int NTAP   = KERNEL_W * KERNEL_W;
  localparam int CENTER = (NTAP - 1) / 2;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(NTAP);

  logic signed [COEF_W-1:0] coef_sh  [NTAP];
  logic signed [COEF_W-1:0] coef_act [NTAP];
  logic [SHIFT_W-1:0]       shift_sh, shift_act;

  logic                     en;
  logic                     s1_valid, s2_valid;
  logic signed [PROD_W-1:0] s1_prod [NTAP];
  logic [SHIFT_W-1:0]       s1_shift, s2_shift;
  logic signed [SUM_W-1:0]  s2_sum, tree_sum;
  logic signed [SUM_W:0]    rnd_ext, rnd_val;
  logic [SUM_W:0]           rnd_bias;
  logic [DATA_W-1:0]        sat_pix;
  logic                     sat_flag;

  assign en                 = !pixel_valid_o || pixel_ready_i;
  assign pixel_data_ready_o = en;

  // Swap copies the pre-write shadow because both sides are non-blocking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAP; i++) begin
        coef_sh[i]  <= (i == CENTER) ? COEF_W'(1) : COEF_W'(0);
        coef_act[i] <= (i == CENTER) ? COEF_W'(1) : COEF_W'(0);
      end
      shift_sh  <= '0;
      shift_act <= '0;
    end else begin
      if (coef_wr_i && (32'(coef_addr_i) < NTAP))
        coef_sh[coef_addr_i] <= coef_data_i;
      if (shift_wr_i)
        shift_sh <= shift_data_i;
      if (coef_swap_i) begin
        coef_act  <= coef_sh;
        shift_act <= shift_sh;
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < NTAP; i++)
      tree_sum = tree_sum + SUM_W'(s1_prod[i]);
  end

  // Bias is 2^(shift-1) for shift >= 1 and zero for shift = 0.
  always_comb begin
    rnd_ext  = (SUM_W+1)'(s2_sum);
    rnd_bias = ((SUM_W+1)'(1) << s2_shift) >> 1;
    rnd_val  = (rnd_ext + $signed(rnd_bias)) >>> s2_shift;
    sat_pix  = rnd_val[DATA_W-1:0];
    sat_flag = 1'b0;
    if (rnd_val[SUM_W]) begin
      sat_pix  = '0;
      sat_flag = 1'b1;
    end else if (|rnd_val[SUM_W-1:DATA_W]) begin
      sat_pix  = '1;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid      <= 1'b0;
      s1_shift      <= '0;
      for (int i = 0; i < NTAP; i++) s1_prod[i] <= '0;
      s2_valid      <= 1'b0;
      s2_sum        <= '0;
      s2_shift      <= '0;
      pixel_valid_o <= 1'b0;
      pixel_o       <= '0;
      pixel_sat_o   <= 1'b0;
    end else if (en) begin
      s1_valid <= pixel_data_valid_i;
      s1_shift <= shift_act;
      for (int r = 0; r < KERNEL_W; r++)
        for (int c = 0; c < KERNEL_W; c++)
          s1_prod[r*KERNEL_W+c] <= PROD_W'($signed({1'b0, pixel_data_i[r][c]}))
                                 * PROD_W'(coef_act[r*KERNEL_W+c]);
      s2_valid      <= s1_valid;
      s2_sum        <= tree_sum;
      s2_shift      <= s1_shift;
      pixel_valid_o <= s2_valid;
      pixel_o       <= sat_pix;
      pixel_sat_o   <= sat_flag;
    end
  end
endmodule

// File: tb/tb_conv_kernel_engine.sv
// Directed bench for conv_kernel_engine: hand-computed 3x3 results, swap ordering,
// backpressure and mid-stream reset.
module tb_conv_kernel_engine;
  typedef logic [2:0][2:0][7:0] win_t;
  typedef logic [8:0][7:0]      ker_t;

  logic       clk_i_tb = 1'b0;
  logic       rst;
  win_t       pix;
  logic       pv, pr_o;
  logic       coef_wr;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic       shift_wr;
  logic [3:0] shift_data;
  logic       coef_swap;
  logic [7:0] pix_o;
  logic       sat, vo, ready_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i_tb = ~clk_i_tb;

  conv_kernel_engine dut (
    .clk_i              (clk_i_tb),
    .rst_i              (rst),
    .pixel_data_i       (pix),
    .pixel_data_valid_i (pv),
    .pixel_data_ready_o (pr_o),
    .coef_wr_i          (coef_wr),
    .coef_addr_i        (coef_addr),
    .coef_data_i        (coef_data),
    .shift_wr_i         (shift_wr),
    .shift_data_i       (shift_data),
    .coef_swap_i        (coef_swap),
    .pixel_o            (pix_o),
    .pixel_sat_o        (sat),
    .pixel_valid_o      (vo),
    .pixel_ready_i      (ready_i)
  );

  task automatic tick();
    @(posedge clk_i_tb);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic win_t mk_win(input int a, b, c, d, e, f, g, h, i);
    win_t w;
    w[0][0] = 8'(a); w[0][1] = 8'(b); w[0][2] = 8'(c);
    w[1][0] = 8'(d); w[1][1] = 8'(e); w[1][2] = 8'(f);
    w[2][0] = 8'(g); w[2][1] = 8'(h); w[2][2] = 8'(i);
    return w;
  endfunction

  task automatic load_kernel(input ker_t k, input logic [3:0] sh, input logic do_swap);
    for (int i = 0; i < 9; i++) begin
      coef_wr = 1'b1; coef_addr = 4'(i); coef_data = k[i];
      tick();
    end
    coef_wr = 1'b0;
    shift_wr = 1'b1; shift_data = sh;
    tick();
    shift_wr = 1'b0;
    if (do_swap) begin
      coef_swap = 1'b1;
      tick();
      coef_swap = 1'b0;
    end
  endtask

  task automatic run_one(input string tag, input win_t w, input int ep, input int es);
    pv = 1'b1; pix = w;
    tick();
    pv = 1'b0;
    tick();
    tick();
    check({tag, "_valid"}, 32'(vo), 1);
    check({tag, "_pix"}, 32'(pix_o), 32'(ep));
    check({tag, "_sat"}, 32'(sat), 32'(es));
    tick();
  endtask

  win_t w0, w255;
  ker_t k_id, k_box, k_sharp, k_max, k_neg;
  win_t bw [5];
  int   bexp [5];
  int   sent, recv;
  logic acc;

  initial begin
    rst = 1'b1; pv = 1'b0; pix = '0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    shift_wr = 1'b0; shift_data = '0; coef_swap = 1'b0; ready_i = 1'b1;

    w0   = mk_win(0, 1, 1, 15, 16, 17, 18, 19, 20);
    w255 = mk_win(255, 255, 255, 255, 255, 255, 255, 255, 255);
    k_id = '0;  k_id[4] = 8'd1;
    k_box = {9{8'd1}};
    k_sharp = {9{8'hFF}}; k_sharp[4] = 8'd8;
    k_max = {9{8'd127}};
    k_neg = '0; k_neg[4] = 8'hFF;

    tick(); tick();
    check("rst_valid", 32'(vo), 0);
    check("rst_pix", 32'(pix_o), 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_ready", 32'(pr_o), 1);
    rst = 1'b0;
    tick();

    // Identity kernel after reset, valid held: result on the third edge counting the accept edge.
    pv = 1'b1; pix = w0;
    tick(); check("lat_e1_valid", 32'(vo), 0);
    tick(); check("lat_e2_valid", 32'(vo), 0);
    tick(); check("lat_e3_valid", 32'(vo), 1);
    check("id_pix", 32'(pix_o), 16);
    check("id_sat", 32'(sat), 0);
    pv = 1'b0;
    tick(); tick(); tick();
    check("drain_valid", 32'(vo), 0);

    load_kernel(k_box, 4'd3, 1'b1);
    run_one("box", w0, 13, 0);
    load_kernel(k_sharp, 4'd0, 1'b1);
    run_one("sharp", w0, 37, 0);
    load_kernel(k_max, 4'd0, 1'b1);
    run_one("sat_hi", w255, 255, 1);
    load_kernel(k_neg, 4'd0, 1'b1);
    run_one("sat_lo", w0, 0, 1);

    // Swap on the accept cycle of window N, plus a shadow write that must not reach N+1.
    load_kernel(k_id, 4'd0, 1'b1);
    load_kernel(k_box, 4'd3, 1'b0);
    pv = 1'b1; pix = w0;
    coef_swap = 1'b1; coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'd100;
    tick();
    coef_swap = 1'b0; coef_wr = 1'b0;
    tick();
    pv = 1'b0;
    tick();
    check("swap_n_valid", 32'(vo), 1);
    check("swap_n_pix", 32'(pix_o), 16);
    tick();
    check("swap_n1_valid", 32'(vo), 1);
    check("swap_n1_pix", 32'(pix_o), 13);
    tick();

    // Backpressure: five distinct windows through the identity kernel.
    load_kernel(k_id, 4'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bw[k]   = mk_win(k+3, k+3, k+3, k+3, 10*(k+1), k+3, k+3, k+3, k+3);
      bexp[k] = 10 * (k + 1);
    end
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      ready_i = !(cyc >= 3 && cyc <= 6);
      #1;
      if (cyc == 3) check("bp_stall_valid", 32'(vo), 1);
      if (vo) begin
        if (recv < 5) check("bp_data", 32'(pix_o), 32'(bexp[recv]));
        else check("bp_extra", 32'(vo), 0);
        if (ready_i) recv++;
        else check("bp_ready_low", 32'(pr_o), 0);
      end
      pv = (sent < 5);
      if (sent < 5) pix = bw[sent];
      acc = pv && pr_o;
      tick();
      if (acc) sent++;
    end
    pv = 1'b0;
    check("bp_recv_count", 32'(recv), 5);
    check("bp_sent_count", 32'(sent), 5);
    check("bp_idle_valid", 32'(vo), 0);

    // Reset with results in flight; box active and a sharpen kernel pending in the shadow.
    load_kernel(k_box, 4'd3, 1'b1);
    load_kernel(k_sharp, 4'd0, 1'b0);
    pv = 1'b1; pix = w0;
    tick(); tick(); tick();
    check("pre_rst_valid", 32'(vo), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(vo), 0);
    check("mid_rst_pix", 32'(pix_o), 0);
    pv = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_idle", 32'(vo), 0);
    run_one("post_rst", w0, 16, 0);
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    run_one("post_rst_swap", w0, 16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
